// File: rtl/dmem_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_stage_ctrl                                            |
// | Description : MEM-stage data-cache request/response controller with      |
// |               stall, store alignment and load extension.                 |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module dmem_stage_ctrl #(
    parameter int ALIGN_CHECK  = 1,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        advance,
    input  logic        flush,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        mem_error
);

    localparam int c_WD_W = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic               r_is_load;
    logic               r_drop;
    logic [c_WD_W-1:0]  r_wd;

    logic        w_access;
    logic        w_unaligned;
    logic        w_mis_cond;
    logic        w_req;
    logic [1:0]  w_off;
    logic        w_timeout;
    logic        w_discard;
    logic [31:0] w_shift;
    logic [31:0] w_ext;

    assign w_access    = in_valid & (mem_read | mem_write);
    assign w_unaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                         ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    assign w_mis_cond  = (ALIGN_CHECK != 0) & w_unaligned;
    // A sticky watchdog error keeps the held instruction from being reissued.
    assign w_req       = (r_state == ST_IDLE) & w_access & ~flush & ~w_mis_cond & ~mem_error;
    assign w_off       = (w_unaligned && ALIGN_CHECK == 0) ? 2'b00 : addr[1:0];
    assign w_timeout   = (RESP_TIMEOUT > 0) && (r_wd == c_WD_LAST);
    assign w_discard   = r_drop | flush;

    assign misalign = (r_state == ST_IDLE) & w_access & ~flush & w_mis_cond;
    assign stall    = (r_state == ST_BUSY) | w_req;

    assign w_shift = dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shift;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {24'd0, w_shift[7:0]};
            3'b101:  w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_is_load    <= 1'b0;
            r_drop       <= 1'b0;
            r_wd         <= '0;
            dmem_address <= 32'd0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_wmask   <= 4'd0;
            dmem_wdata   <= 32'd0;
            load_data    <= 32'd0;
            mem_error    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state      <= ST_BUSY;
                        dmem_address <= {addr[31:2], 2'b00};
                        dmem_write   <= mem_write;
                        dmem_read    <= mem_read & ~mem_write;
                        dmem_wmask   <= mem_write ? (mem_byte_enable << w_off) : 4'd0;
                        dmem_wdata   <= wdata << {w_off, 3'b000};
                        r_funct3     <= funct3;
                        r_off        <= w_off;
                        r_is_load    <= mem_read & ~mem_write;
                        r_drop       <= 1'b0;
                        r_wd         <= '0;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    // A response in the final watchdog cycle still completes normally.
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        if (r_is_load && !w_discard) begin
                            load_data <= w_ext;
                        end
                        r_state <= w_discard ? ST_IDLE : ST_DONE;
                        r_drop  <= 1'b0;
                        r_wd    <= '0;
                    end else if (w_timeout) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        mem_error  <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_drop     <= 1'b0;
                        r_wd       <= '0;
                    end else begin
                        r_wd <= r_wd + c_WD_W'(1);
                    end
                end
                ST_DONE: begin
                    if (advance) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_stage_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_stage_ctrl                                         |
// | Description : Self-checking bench for dmem_stage_ctrl.                   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_dmem_stage_ctrl;

    localparam int c_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        advance;
    logic        flush;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign;
    logic        mem_error;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ld = 32'd0;

    always #5 clk = ~clk;

    dmem_stage_ctrl #(
        .ALIGN_CHECK  (1),
        .RESP_TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .funct3          (funct3),
        .addr            (addr),
        .wdata           (wdata),
        .advance         (advance),
        .flush           (flush),
        .dmem_address    (dmem_address),
        .dmem_read       (dmem_read),
        .dmem_write      (dmem_write),
        .dmem_wmask      (dmem_wmask),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_resp       (dmem_resp),
        .stall           (stall),
        .load_data       (load_data),
        .misalign        (misalign),
        .mem_error       (mem_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] off,
                                           input logic [2:0] f3);
        int unsigned v;
        v = raw / (32'd1 << (8 * off));
        case (f3)
            3'b000:  return (v % 256 >= 128) ? 32'(v % 256) - 32'd256 : 32'(v % 256);
            3'b001:  return (v % 65536 >= 32768) ? 32'(v % 65536) - 32'd65536 : 32'(v % 65536);
            3'b100:  return 32'(v % 256);
            3'b101:  return 32'(v % 65536);
            default: return 32'(v);
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
        funct3 = 0; addr = 0; wdata = 0; advance = 0; flush = 0;
        dmem_resp = 0; dmem_rdata = 0;
    endtask

    // One MEM-stage access: lat = cycle of response, flush_cyc = BUSY cycle with flush (0 none).
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic [31:0] rdat, input int flush_cyc, input int adv_delay);
        int          size;
        bit          mis;
        bit          is_wr;
        bit          dropped;
        logic [3:0]  be;
        logic [31:0] e_mask;
        logic [31:0] e_wdata;
        size    = int'(f3 % 4);
        mis     = (size == 1 && a % 2 == 1) || (size == 2 && a % 4 != 0);
        be      = (size == 0) ? 4'b0001 : (size == 1) ? 4'b0011 : 4'b1111;
        is_wr   = wr;
        e_mask  = is_wr ? 32'(be) * (32'd1 << (a % 4)) % 16 : 32'd0;
        e_wdata = wd * (32'd1 << (8 * (a % 4)));
        dropped = 0;

        @(negedge clk);
        in_valid = 1; mem_read = rd; mem_write = wr; mem_byte_enable = be;
        funct3 = f3; addr = a; wdata = wd; advance = 0; flush = 0; dmem_resp = 0;
        #1;
        if (mis) begin
            chk("misalign_flag", misalign, 1);
            chk("misalign_stall", stall, 0);
            @(negedge clk);
            #1;
            chk("misalign_noread", dmem_read, 0);
            chk("misalign_nowrite", dmem_write, 0);
            in_valid = 0;
            #1;
            chk("misalign_clear", misalign, 0);
            return;
        end
        chk("issue_misalign", misalign, 0);
        chk("issue_stall", stall, 1);
        chk("issue_read_low", dmem_read, 0);

        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            flush      = (c == flush_cyc);
            if (flush) in_valid = 0;
            dmem_resp  = (c == lat);
            dmem_rdata = (c == lat) ? rdat : $urandom;
            #1;
            if (flush) dropped = 1;
            chk("busy_stall", stall, 1);
            chk("busy_read", dmem_read, rd && !wr);
            chk("busy_write", dmem_write, is_wr);
            chk("busy_addr", dmem_address, a - (a % 4));
            chk("busy_wmask", dmem_wmask, e_mask);
            chk("busy_wdata", dmem_wdata, e_wdata);
        end
        if (rd && !wr && !dropped) exp_ld = extend(rdat, a[1:0], f3);

        @(negedge clk);
        dmem_resp = 0; flush = 0; advance = (adv_delay == 0);
        #1;
        chk("post_stall", stall, 0);
        chk("post_read", dmem_read, 0);
        chk("post_write", dmem_write, 0);
        chk("post_load_data", load_data, exp_ld);
        if (dropped) return;
        for (int d = 1; d <= adv_delay; d++) begin
            @(negedge clk);
            advance = (d == adv_delay);
            dmem_resp = 1;
            #1;
            chk("done_hold_stall", stall, 0);
            chk("done_no_reissue", dmem_read | dmem_write, 0);
            chk("done_load_data", load_data, exp_ld);
        end
        @(negedge clk);
        in_valid = 0; advance = 0; dmem_resp = 0;
        #1;
        chk("after_adv_stall", stall, 0);
        chk("after_adv_load_data", load_data, exp_ld);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_address", dmem_address, 0);
        chk("rst_read", dmem_read, 0);
        chk("rst_write", dmem_write, 0);
        chk("rst_wmask", dmem_wmask, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_mem_error", mem_error, 0);

        // Directed scenarios
        access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 0);
        chk("lw_value", load_data, 32'hDEADBEEF);
        access(0, 1, 3'b000, 32'h103, 32'h000000A5, 2, 32'h0, 0, 1);
        access(1, 0, 3'b000, 32'h102, 32'h0, 1, 32'h00800000, 0, 0);
        chk("lb_value", load_data, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h102, 32'h0, 1, 32'h00800000, 0, 2);
        chk("lbu_value", load_data, 32'h00000080);
        access(1, 0, 3'b001, 32'h101, 32'h0, 1, 32'h0, 0, 0);
        access(1, 0, 3'b010, 32'h100, 32'h0, 3, 32'h12345678, 1, 0);
        chk("flush_keeps_load", load_data, 32'h00000080);
        access(1, 1, 3'b010, 32'h204, 32'hCAFEF00D, 8, 32'h11111111, 0, 0);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            int          op;
            int          lat;
            int          fc;
            op = $urandom_range(0, 2);
            rd = (op != 1);
            wr = (op != 0);
            if (!wr) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            lat = $urandom_range(1, c_TIMEOUT);
            fc  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            access(rd, wr, f3, a, $urandom, lat, $urandom, fc, $urandom_range(0, 2));
        end

        // Watchdog expiry with no response
        @(negedge clk);
        in_valid = 1; mem_read = 1; mem_write = 0; mem_byte_enable = 4'hF;
        funct3 = 3'b010; addr = 32'h300;
        #1;
        chk("wd_issue_stall", stall, 1);
        for (int c = 1; c <= c_TIMEOUT; c++) begin
            @(negedge clk);
            #1;
            chk("wd_busy_read", dmem_read, 1);
            chk("wd_busy_stall", stall, 1);
            chk("wd_no_error_yet", mem_error, 0);
        end
        @(negedge clk);
        #1;
        chk("wd_error", mem_error, 1);
        chk("wd_read_dropped", dmem_read, 0);
        chk("wd_stall_low", stall, 0);
        @(negedge clk);
        dmem_resp = 1; dmem_rdata = 32'h5A5A5A5A;
        #1;
        chk("wd_error_sticky", mem_error, 1);
        chk("wd_late_resp_ignored", dmem_read, 0);
        @(negedge clk);
        dmem_resp = 0; in_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_clears_error", mem_error, 0);

        // Reset in the middle of BUSY
        in_valid = 1; mem_read = 1; mem_write = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_busy_read", dmem_read, 1);
        rst = 1; in_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_busy_read", dmem_read, 0);
        chk("rst_busy_stall", stall, 0);
        chk("rst_busy_load_data", load_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
